// File: rtl/vend_pkg.sv
// Shared types and coin values for the multi-item vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        VEND,
        CHANGE
    } vend_state_t;

    localparam int COIN50_U  = 1;
    localparam int COIN100_U = 2;

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Front-end/actuator bundle for vend_ctrl_multi; master = coin/keypad side, slave = controller.
// Stock ports (sold_out, restock_valid, restock_item) exist only when VEND_STOCK_EN is defined.
interface vend_ctrl_multi_if #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W  = 4
);
    localparam int IW = $clog2(NUM_ITEMS);

    logic                fifty_in;
    logic                hundred_in;
    logic                sel_valid;
    logic [IW-1:0]       sel_item;
    logic                cancel;
    logic                dispense_ready;
    logic                drop_out;
    logic [IW-1:0]       drop_item;
    logic                change_out;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
`ifdef VEND_STOCK_EN
    logic [NUM_ITEMS-1:0] sold_out;
    logic                 restock_valid;
    logic [IW-1:0]        restock_item;

    modport master (
        output fifty_in, hundred_in, sel_valid, sel_item, cancel, dispense_ready,
               restock_valid, restock_item,
        input  drop_out, drop_item, change_out, coin_reject, credit, busy, sold_out
    );
    modport slave (
        input  fifty_in, hundred_in, sel_valid, sel_item, cancel, dispense_ready,
               restock_valid, restock_item,
        output drop_out, drop_item, change_out, coin_reject, credit, busy, sold_out
    );
`else
    modport master (
        output fifty_in, hundred_in, sel_valid, sel_item, cancel, dispense_ready,
        input  drop_out, drop_item, change_out, coin_reject, credit, busy
    );
    modport slave (
        input  fifty_in, hundred_in, sel_valid, sel_item, cancel, dispense_ready,
        output drop_out, drop_item, change_out, coin_reject, credit, busy
    );
`endif

endinterface

// File: rtl/vend_stock_table.sv
// Per-item stock counters: decrement on dispense handshake, reload to STOCK_INIT on restock.
// sold_out is decoded from the registered counters, so it changes the cycle after the event.
module vend_stock_table #(
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_INIT = 15
) (
    input  logic                         clk,
    input  logic                         rstout,
    input  logic                         dec,
    input  logic [$clog2(NUM_ITEMS)-1:0] dec_item,
    input  logic                         reload,
    input  logic [$clog2(NUM_ITEMS)-1:0] reload_item,
    output logic [NUM_ITEMS-1:0]         sold_out
);
    localparam int SW = $clog2(STOCK_INIT + 1);
    localparam logic [SW-1:0] INIT = SW'(STOCK_INIT);

    logic [SW-1:0] stock [NUM_ITEMS];

    always_ff @(posedge clk or posedge rstout) begin
        if (rstout) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= INIT;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (reload && int'(reload_item) == i)
                    stock[i] <= INIT;
                else if (dec && int'(dec_item) == i && stock[i] != '0)
                    stock[i] <= stock[i] - 1'b1;
            end
        end
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock[i] == '0);
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: coin credit, select/vend handshake, serial change; all outputs registered, 1-cycle latency.
// drop_out holds until dispense_ready; stock tracking and restock ports are added when VEND_STOCK_EN is defined.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS    = 4,
    parameter int PRICE_U      = 3,
    parameter int MAX_CREDIT_U = 6,
    parameter int CREDIT_W     = 4
`ifdef VEND_STOCK_EN
    ,
    parameter int STOCK_INIT   = 15
`endif
) (
    input  logic          clk,
    input  logic          rstout,
    vend_ctrl_multi_if.slave bus
);
    localparam int IW = $clog2(NUM_ITEMS);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_U);
    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W + 1)'(MAX_CREDIT_U);
    localparam logic [CREDIT_W:0]   C50     = (CREDIT_W + 1)'(COIN50_U);
    localparam logic [CREDIT_W:0]   C100    = (CREDIT_W + 1)'(COIN100_U);

    vend_state_t         state, state_nx;
    logic [CREDIT_W-1:0] credit_q, credit_nx;
    logic                drop_q, drop_nx;
    logic [IW-1:0]       item_q, item_nx;
    logic                change_q, change_nx;
    logic                reject_q, reject_nx;
    logic                busy_q, busy_nx;

    logic                coin_any;
    logic                coin_fits;
    logic [CREDIT_W:0]   coin_sum;
    logic                in_stock;
    logic                sel_ok;
    logic                handshake;

    assign handshake = (state == VEND) && drop_q && bus.dispense_ready;

`ifdef VEND_STOCK_EN
    logic [NUM_ITEMS-1:0] sold_out;

    vend_stock_table #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_INIT (STOCK_INIT)
    ) u_stock (
        .clk         (clk),
        .rstout      (rstout),
        .dec         (handshake),
        .dec_item    (item_q),
        .reload      ((state == IDLE) && bus.restock_valid),
        .reload_item (bus.restock_item),
        .sold_out    (sold_out)
    );

    assign bus.sold_out = sold_out;
    assign in_stock     = !sold_out[bus.sel_item];
`else
    assign in_stock = 1'b1;
`endif

    always_comb begin
        coin_any  = bus.fifty_in | bus.hundred_in;
        coin_sum  = {1'b0, credit_q} + (bus.hundred_in ? C100 : C50);
        // two coins in one cycle cannot be valued reliably, so both bounce
        coin_fits = !(bus.fifty_in & bus.hundred_in) && (coin_sum <= MAX_C);
        sel_ok    = bus.sel_valid && (credit_q >= PRICE_C) &&
                    (int'(bus.sel_item) < NUM_ITEMS) && in_stock;
    end

    always_comb begin
        state_nx  = state;
        credit_nx = credit_q;
        drop_nx   = drop_q;
        item_nx   = item_q;
        change_nx = 1'b0;
        reject_nx = 1'b0;

        case (state)
            IDLE: begin
                if (coin_any) begin
                    if (coin_fits) begin
                        credit_nx = coin_sum[CREDIT_W-1:0];
                        state_nx  = CREDIT;
                    end else begin
                        reject_nx = 1'b1;
                    end
                end
            end
            CREDIT: begin
                if (bus.cancel) begin
                    reject_nx = coin_any;
                    change_nx = 1'b1;
                    state_nx  = CHANGE;
                end else if (bus.sel_valid) begin
                    reject_nx = coin_any;
                    if (sel_ok) begin
                        item_nx  = bus.sel_item;
                        drop_nx  = 1'b1;
                        state_nx = VEND;
                    end
                end else if (coin_any) begin
                    if (coin_fits) credit_nx = coin_sum[CREDIT_W-1:0];
                    else           reject_nx = 1'b1;
                end
            end
            VEND: begin
                reject_nx = coin_any;
                if (handshake) begin
                    drop_nx   = 1'b0;
                    credit_nx = credit_q - PRICE_C;
                    if (credit_nx != '0) begin
                        change_nx = 1'b1;
                        state_nx  = CHANGE;
                    end else begin
                        state_nx  = IDLE;
                    end
                end
            end
            CHANGE: begin
                reject_nx = coin_any;
                if (credit_q == '0) begin
                    state_nx = IDLE;
                end else begin
                    // change_out mirrors the unit being paid out this cycle
                    credit_nx = credit_q - 1'b1;
                    if (credit_nx == '0) state_nx = IDLE;
                    else                 change_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx == VEND) || (state_nx == CHANGE);
    end

    always_ff @(posedge clk or posedge rstout) begin
        if (rstout) begin
            state    <= IDLE;
            credit_q <= '0;
            drop_q   <= 1'b0;
            item_q   <= '0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            credit_q <= credit_nx;
            drop_q   <= drop_nx;
            item_q   <= item_nx;
            change_q <= change_nx;
            reject_q <= reject_nx;
            busy_q   <= busy_nx;
        end
    end

    assign bus.drop_out    = drop_q;
    assign bus.drop_item   = item_q;
    assign bus.change_out  = change_q;
    assign bus.coin_reject = reject_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi with a vend/change scoreboard; stock steps run when VEND_STOCK_EN is defined.
module tb_vend_ctrl_multi;

    logic clk = 1'b0;
    logic rstout;
    always #5 clk = ~clk;

    vend_ctrl_multi_if #(.NUM_ITEMS(4), .CREDIT_W(4)) bus ();

    vend_ctrl_multi #(
        .NUM_ITEMS    (4),
        .PRICE_U      (3),
        .MAX_CREDIT_U (6),
        .CREDIT_W     (4)
`ifdef VEND_STOCK_EN
        ,
        .STOCK_INIT   (1)
`endif
    ) dut (
        .clk    (clk),
        .rstout (rstout),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] item;
        int         hold;
    } vend_t;

    vend_t vend_q[$];
    int    change_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic outs(input string tag, input logic drop, input logic chg, input logic rej,
                        input logic [3:0] cr, input logic bsy);
        check({tag, ".drop_out"},    32'(bus.drop_out),    32'(drop));
        check({tag, ".change_out"},  32'(bus.change_out),  32'(chg));
        check({tag, ".coin_reject"}, 32'(bus.coin_reject), 32'(rej));
        check({tag, ".credit"},      32'(bus.credit),      32'(cr));
        check({tag, ".busy"},        32'(bus.busy),        32'(bsy));
    endtask

    task automatic coin(input logic f, input logic h);
        bus.fifty_in   = f;
        bus.hundred_in = h;
        tick();
        bus.fifty_in   = 1'b0;
        bus.hundred_in = 1'b0;
    endtask

    // expect: push a vend record of the given hold length; fifty rides along in the same cycle
    task automatic select(input logic [1:0] it, input logic expect_vend, input int hold, input logic f);
        vend_t v;
        if (expect_vend) begin
            v.item = it;
            v.hold = hold;
            vend_q.push_back(v);
        end
        bus.sel_item  = it;
        bus.sel_valid = 1'b1;
        bus.fifty_in  = f;
        tick();
        bus.sel_valid = 1'b0;
        bus.fifty_in  = 1'b0;
    endtask

    task automatic ready();
        bus.dispense_ready = 1'b1;
        tick();
        bus.dispense_ready = 1'b0;
    endtask

    task automatic cancel_req(input int n);
        change_q.push_back(n);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
    endtask

    // Scoreboard monitor: measures each drop_out and change_out run
    logic       drop_prev = 1'b0;
    logic       chg_prev  = 1'b0;
    int         drop_cnt  = 0;
    int         chg_cnt   = 0;
    logic [1:0] drop_first;

    always @(negedge clk) begin
        if (bus.drop_out) begin
            if (!drop_prev) drop_first = bus.drop_item;
            drop_cnt++;
        end else if (drop_prev) begin
            check("vend_expected", 32'(vend_q.size() != 0), 32'd1);
            if (vend_q.size() != 0) begin
                vend_t v;
                v = vend_q.pop_front();
                check("vend_item", 32'(drop_first), 32'(v.item));
                check("vend_hold", 32'(drop_cnt), 32'(v.hold));
            end
            drop_cnt = 0;
        end
        drop_prev = bus.drop_out;

        if (bus.change_out) begin
            chg_cnt++;
        end else if (chg_prev) begin
            check("change_expected", 32'(change_q.size() != 0), 32'd1);
            if (change_q.size() != 0) check("change_len", 32'(chg_cnt), 32'(change_q.pop_front()));
            chg_cnt = 0;
        end
        chg_prev = bus.change_out;
    end

    initial begin
        rstout             = 1'b1;
        bus.fifty_in       = 1'b0;
        bus.hundred_in     = 1'b0;
        bus.sel_valid      = 1'b0;
        bus.sel_item       = '0;
        bus.cancel         = 1'b0;
        bus.dispense_ready = 1'b0;
`ifdef VEND_STOCK_EN
        bus.restock_valid  = 1'b0;
        bus.restock_item   = '0;
`endif
        tick();
        tick();
        outs("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        check("reset.drop_item", 32'(bus.drop_item), 32'd0);
        rstout = 1'b0;
        tick();

        // cancel and stray dispense_ready in IDLE do nothing
        bus.cancel = 1'b1;
        bus.dispense_ready = 1'b1;
        tick();
        bus.cancel = 1'b0;
        bus.dispense_ready = 1'b0;
        outs("idle_ignore", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // exact price, slow mechanism
        coin(1'b0, 1'b1);
        outs("t1.c100", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        coin(1'b1, 1'b0);
        outs("t1.c50", 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
        select(2'd2, 1'b1, 3, 1'b0);
        outs("t1.sel", 1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
        check("t1.drop_item", 32'(bus.drop_item), 32'd2);
        repeat (2) tick();
        ready();
        outs("t1.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();

        // overpay by one unit, immediate handshake
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        outs("t2.coins", 1'b0, 1'b0, 1'b0, 4'd4, 1'b0);
        select(2'd1, 1'b1, 1, 1'b0);
        change_q.push_back(1);
        ready();
        outs("t2.vend", 1'b0, 1'b1, 1'b0, 4'd1, 1'b1);
        tick();
        outs("t2.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // ceiling reject then full refund
        repeat (3) coin(1'b0, 1'b1);
        outs("t3.full", 1'b0, 1'b0, 1'b0, 4'd6, 1'b0);
        coin(1'b1, 1'b0);
        outs("t3.reject", 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
        tick();
        check("t3.reject_pulse", 32'(bus.coin_reject), 32'd0);
        cancel_req(6);
        outs("t3.cancel", 1'b0, 1'b1, 1'b0, 4'd6, 1'b1);
        repeat (6) tick();
        outs("t3.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // simultaneous coins, then underfunded select and stray ready
        coin(1'b1, 1'b1);
        outs("t4.both", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        coin(1'b0, 1'b1);
        select(2'd0, 1'b0, 0, 1'b0);
        outs("t4.poor_sel", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        ready();
        outs("t4.stray_rdy", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        cancel_req(2);
        repeat (2) tick();
        outs("t4.done", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // coin loses to select; reset during change
        repeat (3) coin(1'b0, 1'b1);
        select(2'd3, 1'b1, 1, 1'b1);
        outs("t5.sel_coin", 1'b1, 1'b0, 1'b1, 4'd6, 1'b1);
        check("t5.drop_item", 32'(bus.drop_item), 32'd3);
        change_q.push_back(1);
        ready();
        outs("t5.change", 1'b0, 1'b1, 1'b0, 4'd3, 1'b1);
        #1 rstout = 1'b1;
        tick();
        outs("t5.reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        check("t5.drop_item_rst", 32'(bus.drop_item), 32'd0);
        rstout = 1'b0;
        tick();

`ifdef VEND_STOCK_EN
        coin(1'b0, 1'b1);
        coin(1'b1, 1'b0);
        select(2'd0, 1'b1, 1, 1'b0);
        ready();
        check("s.sold_out0", 32'(bus.sold_out), 32'b0001);
        coin(1'b0, 1'b1);
        coin(1'b1, 1'b0);
        select(2'd0, 1'b0, 0, 1'b0);
        outs("s.empty_sel", 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
        cancel_req(3);
        repeat (3) tick();
        bus.restock_valid = 1'b1;
        bus.restock_item  = 2'd0;
        tick();
        bus.restock_valid = 1'b0;
        check("s.restocked", 32'(bus.sold_out), 32'b0000);
        coin(1'b0, 1'b1);
        coin(1'b1, 1'b0);
        select(2'd0, 1'b1, 1, 1'b0);
        ready();
        check("s.sold_again", 32'(bus.sold_out), 32'b0001);
`endif

        repeat (3) tick();
        check("vend_q_drained", 32'(vend_q.size()), 32'd0);
        check("change_q_drained", 32'(change_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
